// File: rtl/tile_dispatch_controller.sv
// Tile dispatch scheduler: walks C in ROWS x COLS tile rounds, issuing A/B buffer and
// output-writer instructions, then waits for every issued writer to report completion.
module tile_dispatch_controller #(
  parameter int N                   = 4,
  parameter int MAX_MATRIX_LENGTH   = 4096,
  parameter int ROWS_PROCESSORS     = 2,
  parameter int COLS_PROCESSORS     = 2,
  parameter int MEMORY_ADDRESS_BITS = 64,
  parameter int LEN_BITS            = $clog2(MAX_MATRIX_LENGTH + 1)
) (
  input  logic                                                        i_clk,
  input  logic                                                        i_reset,
  input  logic                                                        i_instruction_valid,
  output logic                                                        o_instruction_ready,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                              i_a_memory_addr,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                              i_b_memory_addr,
  input  logic [MEMORY_ADDRESS_BITS-1:0]                              i_c_memory_addr,
  input  logic [LEN_BITS-1:0]                                         i_m_length,
  input  logic [LEN_BITS-1:0]                                         i_k_length,
  input  logic [LEN_BITS-1:0]                                         i_n_length,
  output logic                                                        o_done,
  output logic                                                        o_error,
  output logic [ROWS_PROCESSORS-1:0]                                  o_a_input_buffer_instruction_valids,
  input  logic [ROWS_PROCESSORS-1:0]                                  i_a_input_buffer_instruction_readys,
  output logic [ROWS_PROCESSORS*MEMORY_ADDRESS_BITS-1:0]              o_a_input_buffer_address_inputs,
  output logic [ROWS_PROCESSORS*LEN_BITS-1:0]                         o_a_input_buffer_length_inputs,
  output logic [ROWS_PROCESSORS*LEN_BITS-1:0]                         o_a_input_buffer_repeats_inputs,
  output logic [COLS_PROCESSORS-1:0]                                  o_b_input_buffer_instruction_valids,
  input  logic [COLS_PROCESSORS-1:0]                                  i_b_input_buffer_instruction_readys,
  output logic [COLS_PROCESSORS*MEMORY_ADDRESS_BITS-1:0]              o_b_input_buffer_address_inputs,
  output logic [COLS_PROCESSORS*LEN_BITS-1:0]                         o_b_input_buffer_length_inputs,
  output logic [COLS_PROCESSORS*LEN_BITS-1:0]                         o_b_input_buffer_repeats_inputs,
  output logic [ROWS_PROCESSORS*COLS_PROCESSORS-1:0]                  o_output_buffer_instruction_valids,
  input  logic [ROWS_PROCESSORS*COLS_PROCESSORS-1:0]                  i_output_buffer_instruction_readys,
  output logic [ROWS_PROCESSORS*COLS_PROCESSORS*MEMORY_ADDRESS_BITS-1:0] o_output_buffer_address_inputs,
  output logic [ROWS_PROCESSORS*COLS_PROCESSORS-1:0]                  o_output_buffer_by_row_instructions,
  input  logic [ROWS_PROCESSORS*COLS_PROCESSORS-1:0]                  i_output_buffer_completed_valids,
  output logic [ROWS_PROCESSORS*COLS_PROCESSORS-1:0]                  o_output_buffer_completed_readys
);

  localparam int R   = ROWS_PROCESSORS;
  localparam int C   = COLS_PROCESSORS;
  localparam int W   = R * C;
  localparam int MAB = MEMORY_ADDRESS_BITS;

  // S_IDLE wait for command | S_CHECK validate dims | S_ISSUE run rounds | S_DONE report
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                r_state;
  logic [MAB-1:0]            r_a_base, r_b_base, r_c_base;
  logic [LEN_BITS-1:0]       r_m, r_k, r_n;
  logic [LEN_BITS-1:0]       r_tr, r_tc, r_rr_num, r_cr_num, r_rr, r_cr;
  logic                      r_error;
  logic [R-1:0]              r_a_pend;
  logic [C-1:0]              r_b_pend;
  logic [W-1:0]              r_w_pend, r_w_out;
  logic [R-1:0][MAB-1:0]     r_a_addr;
  logic [R-1:0][LEN_BITS-1:0] r_a_len, r_a_rep;
  logic [C-1:0][MAB-1:0]     r_b_addr;
  logic [C-1:0][LEN_BITS-1:0] r_b_len, r_b_rep;
  logic [W-1:0][MAB-1:0]     r_w_addr;

  logic                      w_accept, w_bad, w_round_done, w_last_col, w_last, w_load;
  logic [LEN_BITS-1:0]       w_tr, w_tc, w_rr_num, w_cr_num;
  logic [LEN_BITS-1:0]       w_ld_rr, w_ld_cr, w_ld_tr, w_ld_tc, w_ld_crn;
  logic [R-1:0]              w_row_ok, w_a_act;
  logic [C-1:0]              w_b_act;
  logic [W-1:0]              w_w_act;
  logic [R-1:0][MAB-1:0]     w_a_addr;
  logic [C-1:0][MAB-1:0]     w_b_addr;
  logic [W-1:0][MAB-1:0]     w_w_addr;

  function automatic logic dim_bad(input logic [LEN_BITS-1:0] d);
    return (d == '0) || ((int'(d) % N) != 0) || (int'(d) > MAX_MATRIX_LENGTH);
  endfunction

  assign w_accept = i_instruction_valid && o_instruction_ready;
  assign w_bad    = dim_bad(r_m) || dim_bad(r_k) || dim_bad(r_n);
  assign w_tr     = r_m / LEN_BITS'(N);
  assign w_tc     = r_n / LEN_BITS'(N);
  assign w_rr_num = (w_tr + LEN_BITS'(R - 1)) / LEN_BITS'(R);
  assign w_cr_num = (w_tc + LEN_BITS'(C - 1)) / LEN_BITS'(C);

  assign w_round_done = ~|{r_a_pend, r_b_pend, r_w_pend, r_w_out};
  assign w_last_col   = (r_cr == r_cr_num - LEN_BITS'(1));
  assign w_last       = w_last_col && (r_rr == r_rr_num - LEN_BITS'(1));
  assign w_load       = ((r_state == S_CHECK) && !w_bad) ||
                        ((r_state == S_ISSUE) && w_round_done && !w_last);

  // Coordinates and shape of the round about to be loaded
  assign w_ld_rr  = (r_state == S_CHECK) ? '0 : (w_last_col ? r_rr + LEN_BITS'(1) : r_rr);
  assign w_ld_cr  = (r_state == S_CHECK) ? '0 : (w_last_col ? '0 : r_cr + LEN_BITS'(1));
  assign w_ld_tr  = (r_state == S_CHECK) ? w_tr : r_tr;
  assign w_ld_tc  = (r_state == S_CHECK) ? w_tc : r_tc;
  assign w_ld_crn = (r_state == S_CHECK) ? w_cr_num : r_cr_num;

  for (genvar gr = 0; gr < R; gr++) begin : g_a
    logic [MAB-1:0] w_i;
    assign w_i          = MAB'(w_ld_rr) * MAB'(R) + MAB'(gr);
    assign w_row_ok[gr] = (w_i < MAB'(w_ld_tr));
    assign w_a_act[gr]  = w_row_ok[gr] && (w_ld_cr == '0);
    assign w_a_addr[gr] = r_a_base + w_i * MAB'(N) * MAB'(r_k);
  end

  for (genvar gc = 0; gc < C; gc++) begin : g_b
    logic [MAB-1:0] w_j;
    assign w_j          = MAB'(w_ld_cr) * MAB'(C) + MAB'(gc);
    assign w_b_act[gc]  = (w_j < MAB'(w_ld_tc));
    assign w_b_addr[gc] = r_b_base + w_j * MAB'(N) * MAB'(r_k);
  end

  for (genvar gr = 0; gr < R; gr++) begin : g_wr
    for (genvar gc = 0; gc < C; gc++) begin : g_wc
      localparam int IDX = gr * C + gc;
      logic [MAB-1:0] w_i, w_j;
      assign w_i = MAB'(w_ld_rr) * MAB'(R) + MAB'(gr);
      assign w_j = MAB'(w_ld_cr) * MAB'(C) + MAB'(gc);
      assign w_w_act[IDX]  = w_row_ok[gr] && w_b_act[gc];
      assign w_w_addr[IDX] = r_c_base + w_i * MAB'(N) * MAB'(r_n) + w_j * MAB'(N);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_a_base <= '0;
      r_b_base <= '0;
      r_c_base <= '0;
      r_m      <= '0;
      r_k      <= '0;
      r_n      <= '0;
      r_tr     <= '0;
      r_tc     <= '0;
      r_rr_num <= '0;
      r_cr_num <= '0;
      r_rr     <= '0;
      r_cr     <= '0;
      r_error  <= 1'b0;
      r_a_pend <= '0;
      r_b_pend <= '0;
      r_w_pend <= '0;
      r_w_out  <= '0;
      r_a_addr <= '0;
      r_a_len  <= '0;
      r_a_rep  <= '0;
      r_b_addr <= '0;
      r_b_len  <= '0;
      r_b_rep  <= '0;
      r_w_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a_base <= i_a_memory_addr;
            r_b_base <= i_b_memory_addr;
            r_c_base <= i_c_memory_addr;
            r_m      <= i_m_length;
            r_k      <= i_k_length;
            r_n      <= i_n_length;
            r_error  <= 1'b0;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_tr     <= w_tr;
            r_tc     <= w_tc;
            r_rr_num <= w_rr_num;
            r_cr_num <= w_cr_num;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_a_pend <= r_a_pend & ~i_a_input_buffer_instruction_readys;
          r_b_pend <= r_b_pend & ~i_b_input_buffer_instruction_readys;
          r_w_pend <= r_w_pend & ~i_output_buffer_instruction_readys;
          // Ready only follows a fire, so a writer never fires and completes in one cycle
          r_w_out  <= (r_w_out | (r_w_pend & i_output_buffer_instruction_readys)) &
                      ~(r_w_out & i_output_buffer_completed_valids);
          if (w_round_done && w_last) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        r_rr     <= w_ld_rr;
        r_cr     <= w_ld_cr;
        r_a_pend <= w_a_act;
        r_b_pend <= w_b_act;
        r_w_pend <= w_w_act;
        r_a_addr <= w_a_addr;
        r_b_addr <= w_b_addr;
        r_w_addr <= w_w_addr;
        for (int r = 0; r < R; r++) begin
          r_a_len[r] <= r_k;
          r_a_rep[r] <= w_ld_crn;
        end
        for (int c = 0; c < C; c++) begin
          r_b_len[c] <= r_k;
          r_b_rep[c] <= LEN_BITS'(1);
        end
      end
    end
  end

  assign o_instruction_ready = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_done              = (r_state == S_DONE);
  assign o_error             = r_error;

  assign o_a_input_buffer_instruction_valids = r_a_pend;
  assign o_a_input_buffer_address_inputs     = r_a_addr;
  assign o_a_input_buffer_length_inputs      = r_a_len;
  assign o_a_input_buffer_repeats_inputs     = r_a_rep;
  assign o_b_input_buffer_instruction_valids = r_b_pend;
  assign o_b_input_buffer_address_inputs     = r_b_addr;
  assign o_b_input_buffer_length_inputs      = r_b_len;
  assign o_b_input_buffer_repeats_inputs     = r_b_rep;
  assign o_output_buffer_instruction_valids  = r_w_pend;
  assign o_output_buffer_address_inputs      = r_w_addr;
  assign o_output_buffer_by_row_instructions = '1;
  assign o_output_buffer_completed_readys    = r_w_out;

endmodule

// File: tb/tb_tile_dispatch_controller.sv
// Randomized bench for tile_dispatch_controller: a round-level model predicts every
// handshake, payload and done/error timing.
module tb_tile_dispatch_controller;
  localparam int N = 4, R = 2, C = 2, W = R * C, MAB = 64, LB = 13;
  localparam logic [63:0] A_BASE = 64'h100, B_BASE = 64'h200, C_BASE = 64'h300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, instr_valid, instr_ready, done, error;
  logic [MAB-1:0]    a_base, b_base, c_base;
  logic [LB-1:0]     m_len, k_len, n_len;
  logic [R-1:0]      a_valid, a_rdy;
  logic [R*MAB-1:0]  a_addr;
  logic [R*LB-1:0]   a_len, a_rep;
  logic [C-1:0]      b_valid, b_rdy;
  logic [C*MAB-1:0]  b_addr;
  logic [C*LB-1:0]   b_len, b_rep;
  logic [W-1:0]      w_valid, w_rdy, w_byrow, cmp_valid, cmp_rdy;
  logic [W*MAB-1:0]  w_addr;

  int n_checks = 0;
  int n_fail   = 0;

  tile_dispatch_controller dut (
    .i_clk(clk), .i_reset(reset),
    .i_instruction_valid(instr_valid), .o_instruction_ready(instr_ready),
    .i_a_memory_addr(a_base), .i_b_memory_addr(b_base), .i_c_memory_addr(c_base),
    .i_m_length(m_len), .i_k_length(k_len), .i_n_length(n_len),
    .o_done(done), .o_error(error),
    .o_a_input_buffer_instruction_valids(a_valid), .i_a_input_buffer_instruction_readys(a_rdy),
    .o_a_input_buffer_address_inputs(a_addr), .o_a_input_buffer_length_inputs(a_len),
    .o_a_input_buffer_repeats_inputs(a_rep),
    .o_b_input_buffer_instruction_valids(b_valid), .i_b_input_buffer_instruction_readys(b_rdy),
    .o_b_input_buffer_address_inputs(b_addr), .o_b_input_buffer_length_inputs(b_len),
    .o_b_input_buffer_repeats_inputs(b_rep),
    .o_output_buffer_instruction_valids(w_valid), .i_output_buffer_instruction_readys(w_rdy),
    .o_output_buffer_address_inputs(w_addr), .o_output_buffer_by_row_instructions(w_byrow),
    .i_output_buffer_completed_valids(cmp_valid), .o_output_buffer_completed_readys(cmp_rdy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_drives();
    instr_valid = 1'b0;
    a_rdy = '0; b_rdy = '0; w_rdy = '0; cmp_valid = '0;
  endtask

  task automatic issue(input int m, input int k, input int n);
    check_val("instr_ready", 64'(instr_ready), 64'd1);
    a_base = A_BASE; b_base = B_BASE; c_base = C_BASE;
    m_len = LB'(m); k_len = LB'(k); n_len = LB'(n);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    check_val("done_cleared", 64'(done), 64'd0);
    check_val("error_cleared", 64'(error), 64'd0);
  endtask

  // Which channels take part in round number rnd (row-major over tile rounds)
  task automatic plan(input int rnd, input int cr_n, input int tr, input int tc,
                      output bit [R-1:0] a_e, output bit [C-1:0] b_e, output bit [W-1:0] w_e);
    int rr, cr;
    rr = rnd / cr_n;
    cr = rnd % cr_n;
    for (int r = 0; r < R; r++) a_e[r] = (rr * R + r < tr) && (cr == 0);
    for (int c = 0; c < C; c++) b_e[c] = (cr * C + c < tc);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        w_e[r*C+c] = (rr * R + r < tr) && (cr * C + c < tc);
  endtask

  task automatic run_illegal(input int m, input int k, input int n);
    issue(m, k, n);
    check_val("ill_no_valid_chk", 64'({a_valid, b_valid, w_valid}), 64'd0);
    check_val("ill_done_early", 64'(done), 64'd0);
    @(negedge clk);
    check_val("ill_done", 64'(done), 64'd1);
    check_val("ill_error", 64'(error), 64'd1);
    check_val("ill_no_valid", 64'({a_valid, b_valid, w_valid}), 64'd0);
    @(negedge clk);
    check_val("ill_done_hold", 64'({done, error, instr_ready}), 64'b111);
  endtask

  task automatic run_cmd(input int m, input int k, input int n, input int hold_a1, input int reset_at);
    int tr, tc, rr_n, cr_n, rounds, rnd, rr, cr, cyc, held, gap;
    bit finished, live;
    bit [R-1:0] a_e, a_f;
    bit [C-1:0] b_e, b_f;
    bit [W-1:0] w_e, w_f, w_c, w_o;
    logic [63:0] ti, tj;
    tr = m / N; tc = n / N;
    rr_n = (tr + R - 1) / R; cr_n = (tc + C - 1) / C;
    rounds = rr_n * cr_n;
    issue(m, k, n);
    rnd = 0; cyc = 0; held = 0; gap = 1; finished = 0;
    plan(rnd, cr_n, tr, tc, a_e, b_e, w_e);
    a_f = '0; b_f = '0; w_f = '0; w_c = '0;
    while (!finished && cyc < 3000) begin
      if (reset_at >= 0 && cyc == reset_at) begin
        reset = 1'b1;
        clear_drives();
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_valids", 64'({a_valid, b_valid, w_valid}), 64'd0);
        check_val("rst_cmp_ready", 64'(cmp_rdy), 64'd0);
        check_val("rst_instr_ready", 64'(instr_ready), 64'd1);
        check_val("rst_done", 64'(done), 64'd0);
        return;
      end
      rr = rnd / cr_n; cr = rnd % cr_n;
      live = (gap == 0);
      gap = 0;
      check_val("done_early", 64'(done), 64'd0);
      for (int r = 0; r < R; r++) begin
        check_val($sformatf("a%0d_valid", r), 64'(a_valid[r]), 64'(live && a_e[r] && !a_f[r]));
        if (a_valid[r]) begin
          ti = 64'(rr * R + r);
          check_val($sformatf("a%0d_addr", r), a_addr[r*MAB +: MAB], A_BASE + ti * N * 64'(k));
          check_val($sformatf("a%0d_len", r), 64'(a_len[r*LB +: LB]), 64'(k));
          check_val($sformatf("a%0d_rep", r), 64'(a_rep[r*LB +: LB]), 64'(cr_n));
        end
      end
      for (int c = 0; c < C; c++) begin
        check_val($sformatf("b%0d_valid", c), 64'(b_valid[c]), 64'(live && b_e[c] && !b_f[c]));
        if (b_valid[c]) begin
          tj = 64'(cr * C + c);
          check_val($sformatf("b%0d_addr", c), b_addr[c*MAB +: MAB], B_BASE + tj * N * 64'(k));
          check_val($sformatf("b%0d_len", c), 64'(b_len[c*LB +: LB]), 64'(k));
          check_val($sformatf("b%0d_rep", c), 64'(b_rep[c*LB +: LB]), 64'd1);
        end
      end
      w_o = w_f & ~w_c;
      for (int w = 0; w < W; w++) begin
        check_val($sformatf("w%0d_valid", w), 64'(w_valid[w]), 64'(live && w_e[w] && !w_f[w]));
        check_val($sformatf("w%0d_cmp_ready", w), 64'(cmp_rdy[w]), 64'(w_o[w]));
        if (w_valid[w]) begin
          ti = 64'(rr * R + w / C);
          tj = 64'(cr * C + w % C);
          check_val($sformatf("w%0d_addr", w), w_addr[w*MAB +: MAB],
                    C_BASE + ti * N * 64'(n) + tj * N);
          check_val($sformatf("w%0d_by_row", w), 64'(w_byrow[w]), 64'd1);
        end
      end
      for (int r = 0; r < R; r++) a_rdy[r] = ($urandom % 100) < 60;
      if (a_valid[1] && held < hold_a1) begin
        a_rdy[1] = 1'b0;
        held++;
      end
      for (int c = 0; c < C; c++) b_rdy[c] = ($urandom % 100) < 60;
      for (int w = 0; w < W; w++) begin
        w_rdy[w] = ($urandom % 100) < 60;
        cmp_valid[w] = w_o[w] ? (($urandom % 100) < 50) : (($urandom % 100) < 20);
        if (cmp_valid[w] && w_o[w]) w_c[w] = 1'b1;
      end
      if (live) begin
        a_f = a_f | (a_e & ~a_f & a_rdy);
        b_f = b_f | (b_e & ~b_f & b_rdy);
        w_f = w_f | (w_e & ~w_f & w_rdy);
      end
      if (a_f == a_e && b_f == b_e && w_f == w_e && w_c == w_e) begin
        rnd++;
        if (rnd == rounds) finished = 1;
        else begin
          plan(rnd, cr_n, tr, tc, a_e, b_e, w_e);
          a_f = '0; b_f = '0; w_f = '0; w_c = '0;
          gap = 1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    clear_drives();
    check_val("all_rounds_finished", 64'(finished), 64'd1);
    if (finished) begin
      check_val("done_not_yet", 64'(done), 64'd0);
      @(negedge clk);
      check_val("done", 64'(done), 64'd1);
      check_val("error_legal", 64'(error), 64'd0);
      check_val("done_idle_valids", 64'({a_valid, b_valid, w_valid, cmp_rdy}), 64'd0);
      check_val("done_instr_ready", 64'(instr_ready), 64'd1);
    end else begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, k, n;
    reset = 1'b1;
    clear_drives();
    a_base = '0; b_base = '0; c_base = '0;
    m_len = '0; k_len = '0; n_len = '0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_instr_ready", 64'(instr_ready), 64'd1);
    check_val("rst_done_error", 64'({done, error}), 64'd0);
    check_val("rst_valids", 64'({a_valid, b_valid, w_valid, cmp_rdy}), 64'd0);
    check_val("rst_a_addr", a_addr[63:0], 64'd0);
    check_val("rst_w_addr", w_addr[63:0], 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd(8, 8, 8, 0, -1);
    run_cmd(12, 4, 16, 0, -1);
    run_cmd(8, 8, 8, 5, -1);
    run_illegal(6, 8, 8);
    run_cmd(8, 4, 8, 0, -1);
    run_illegal(0, 4, 4);
    run_illegal(4100, 4, 4);
    run_illegal(8, 8, 10);
    run_cmd(12, 4, 16, 0, 3);
    run_cmd(4, 4, 4, 0, -1);

    for (int it = 0; it < 10; it++) begin
      m = 4 * $urandom_range(1, 6);
      k = 4 * $urandom_range(1, 4);
      n = 4 * $urandom_range(1, 6);
      if ($urandom_range(0, 4) == 0) run_illegal(m, k + 2, n);
      else run_cmd(m, k, n, $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
